cbus_mst: RTL and testbench

CBUS_MST -- requirements
Module: cbus_mst

---
 rtl/cbus_mst.sv | 137 +++++++++++++
 tb/tb_cbus_mst.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_mst.sv
// rtl/cbus_mst.sv - single-outstanding CBUS master: command in, CBUS request/ack, response out.
// Optional ack timeout enabled by defining CBUS_MST_TIMEOUT_EN.
module cbus_mst #(
  parameter int                ADDR_W      = 20,
  parameter int                DATA_W      = 32,
  parameter int                TIMEOUT_CYC = 256,
  parameter logic [DATA_W-1:0] ERR_RDATA   = {DATA_W{1'b1}}
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_sys_n,

  input  logic              i_cmd_vld,
  output logic              o_cmd_rdy,
  input  logic              i_cmd_rw,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,

  output logic              o_rsp_vld,
  input  logic              i_rsp_rdy,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,

  output logic              o_cbus_req,
  output logic              o_cbus_rw,
  input  logic              i_cbus_ack,
  output logic [ADDR_W-1:0] o_cbus_addr,
  output logic [DATA_W-1:0] o_cbus_wdata,
  input  logic [DATA_W-1:0] i_cbus_rdata,

  output logic              o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              timeout_hit;
  logic              cbus_rw;
  logic [ADDR_W-1:0] cbus_addr;
  logic [DATA_W-1:0] cbus_wdata;
  logic [DATA_W-1:0] rsp_rdata;

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_sys_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_cmd_vld) state_nxt = ST_REQ;
      ST_REQ:  if (i_cbus_ack || timeout_hit) state_nxt = ST_RSP;
      ST_RSP:  if (i_rsp_rdy) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef CBUS_MST_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] to_cnt;
  logic        rsp_err;

  // Held at zero outside REQ so every request starts counting from zero.
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_sys_n) begin
      to_cnt <= '0;
    end else if (state != ST_REQ) begin
      to_cnt <= '0;
    end else if (!i_cbus_ack) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  // Ack has priority over an expiring counter.
  assign timeout_hit = (state == ST_REQ) && !i_cbus_ack && (to_cnt == CNT_LAST);

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_sys_n) begin
      rsp_err <= 1'b0;
    end else if (state == ST_REQ) begin
      if (i_cbus_ack) begin
        rsp_err <= 1'b0;
      end else if (timeout_hit) begin
        rsp_err <= 1'b1;
      end
    end
  end

  assign o_rsp_err = rsp_err;
`else
  logic unused_cfg;

  assign unused_cfg  = ^{ERR_RDATA, 16'(TIMEOUT_CYC)};
  assign timeout_hit = 1'b0;
  assign o_rsp_err   = 1'b0;
`endif

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_sys_n) begin
      cbus_rw    <= 1'b0;
      cbus_addr  <= '0;
      cbus_wdata <= '0;
      rsp_rdata  <= '0;
    end else begin
      if (state == ST_IDLE && i_cmd_vld) begin
        cbus_rw    <= i_cmd_rw;
        cbus_addr  <= i_cmd_addr;
        cbus_wdata <= i_cmd_wdata;
      end
      if (state == ST_REQ) begin
        if (i_cbus_ack) begin
          rsp_rdata <= cbus_rw ? '0 : i_cbus_rdata;
        end else if (timeout_hit) begin
          rsp_rdata <= ERR_RDATA;
        end
      end
    end
  end

  assign o_cmd_rdy    = (state == ST_IDLE);
  assign o_busy       = (state != ST_IDLE);
  assign o_cbus_req   = (state == ST_REQ);
  assign o_rsp_vld    = (state == ST_RSP);
  assign o_cbus_rw    = cbus_rw;
  assign o_cbus_addr  = cbus_addr;
  assign o_cbus_wdata = cbus_wdata;
  assign o_rsp_rdata  = rsp_rdata;

endmodule

// File: tb/tb_cbus_mst.sv
// tb/tb_cbus_mst.sv - randomized self-checking bench for cbus_mst against a transaction-level model.
module tb_cbus_mst;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        cmd_rw;
  logic [19:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        cbus_req;
  logic        cbus_rw;
  logic        cbus_ack;
  logic [19:0] cbus_addr;
  logic [31:0] cbus_wdata;
  logic [31:0] cbus_rdata;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  cbus_mst #(.ADDR_W(20), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .i_clk_sys    (clk),
    .i_rst_sys_n  (rst_n),
    .i_cmd_vld    (cmd_vld),
    .o_cmd_rdy    (cmd_rdy),
    .i_cmd_rw     (cmd_rw),
    .i_cmd_addr   (cmd_addr),
    .i_cmd_wdata  (cmd_wdata),
    .o_rsp_vld    (rsp_vld),
    .i_rsp_rdy    (rsp_rdy),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err),
    .o_cbus_req   (cbus_req),
    .o_cbus_rw    (cbus_rw),
    .i_cbus_ack   (cbus_ack),
    .o_cbus_addr  (cbus_addr),
    .o_cbus_wdata (cbus_wdata),
    .i_cbus_rdata (cbus_rdata),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Transaction-level expectation: which cycle ends the request and what comes back.
  function automatic void model(input logic rw, input int ack_at, input logic [31:0] ack_data,
                                output logic [31:0] r, output logic e, output int cyc);
`ifdef CBUS_MST_TIMEOUT_EN
    if (ack_at >= 1 && ack_at <= TO) begin
      cyc = ack_at;
      r   = rw ? 32'h0 : ack_data;
      e   = 1'b0;
    end else begin
      cyc = TO;
      r   = 32'hFFFF_FFFF;
      e   = 1'b1;
    end
`else
    cyc = ack_at;
    r   = rw ? 32'h0 : ack_data;
    e   = 1'b0;
`endif
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   cbus_req,   1'b0);
    check({tag, "_rw"},    cbus_rw,    1'b0);
    check({tag, "_addr"},  cbus_addr,  20'h0);
    check({tag, "_wdata"}, cbus_wdata, 32'h0);
    check({tag, "_rvld"},  rsp_vld,    1'b0);
    check({tag, "_rdata"}, rsp_rdata,  32'h0);
    check({tag, "_err"},   rsp_err,    1'b0);
    check({tag, "_busy"},  busy,       1'b0);
    check({tag, "_crdy"},  cmd_rdy,    1'b1);
  endtask

  task automatic run_txn(input logic rw, input logic [19:0] addr, input logic [31:0] wdata,
                         input int ack_at, input logic [31:0] ack_data, input int hold);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
    int          req_cyc;
    logic        ok;
    model(rw, ack_at, ack_data, exp_rdata, exp_err, exp_cyc);
    @(negedge clk);
    check("cmd_rdy_idle", cmd_rdy, 1'b1);
    cmd_vld   = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(negedge clk);
    cmd_vld   = 1'($urandom_range(0, 1));
    cmd_rw    = 1'($urandom);
    cmd_addr  = 20'($urandom);
    cmd_wdata = $urandom;
    check("busy_req", busy, 1'b1);
    req_cyc = 0;
    ok      = 1'b1;
    while (cbus_req === 1'b1 && req_cyc < 100) begin
      req_cyc++;
      if (cbus_rw !== rw || cbus_addr !== addr || cbus_wdata !== wdata ||
          cmd_rdy !== 1'b0 || rsp_vld !== 1'b0) ok = 1'b0;
      cbus_ack   = (req_cyc == ack_at);
      cbus_rdata = cbus_ack ? ack_data : $urandom;
      @(negedge clk);
    end
    cbus_ack = 1'b0;
    check("req_stable", ok, 1'b1);
    check("req_cycles", 64'(req_cyc), 64'(exp_cyc));
    check("rsp_vld", rsp_vld, 1'b1);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", rsp_err, exp_err);
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      cmd_vld  = 1'b1;
      cmd_rw   = 1'($urandom);
      cmd_addr = 20'($urandom);
      cbus_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rsp_vld !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err ||
          cmd_rdy !== 1'b0 || cbus_req !== 1'b0) ok = 1'b0;
    end
    if (hold > 0) check("rsp_hold", ok, 1'b1);
    cbus_ack = 1'b0;
    cmd_vld  = 1'b0;
    rsp_rdy  = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    check("rsp_done", rsp_vld, 1'b0);
    check("idle_rdy", cmd_rdy, 1'b1);
  endtask

  initial begin
    logic ok;
    rst_n      = 1'b0;
    cmd_vld    = 1'b0;
    cmd_rw     = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    rsp_rdy    = 1'b0;
    cbus_ack   = 1'b0;
    cbus_rdata = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    run_txn(1'b0, 20'h00010, 32'h0, 3, 32'hA5A5_0001, 0);
    run_txn(1'b1, 20'h00020, 32'h1234_5678, 1, 32'hDEAD_BEEF, 0);
    run_txn(1'b0, 20'h00030, 32'h0, 2, 32'h0BAD_F00D, 5);
`ifdef CBUS_MST_TIMEOUT_EN
    run_txn(1'b0, 20'h00040, 32'h0, 0, 32'h0, 1);
    run_txn(1'b0, 20'h00044, 32'h0, TO, 32'h5555_AAAA, 0);
    run_txn(1'b1, 20'h00048, 32'h77, TO + 1, 32'h1, 2);
`endif

    // Stray acks while idle must not start anything.
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cbus_ack   = 1'b1;
      cbus_rdata = $urandom;
      @(negedge clk);
      if (rsp_vld !== 1'b0 || cbus_req !== 1'b0 || cmd_rdy !== 1'b1) ok = 1'b0;
    end
    cbus_ack = 1'b0;
    check("idle_stray_ack", ok, 1'b1);

    for (int n = 0; n < 30; n++) begin
`ifdef CBUS_MST_TIMEOUT_EN
      run_txn(1'($urandom), 20'($urandom), $urandom, $urandom_range(0, TO + 2), $urandom,
              $urandom_range(0, 3));
`else
      run_txn(1'($urandom), 20'($urandom), $urandom, $urandom_range(1, 6), $urandom,
              $urandom_range(0, 3));
`endif
    end

    // Reset during REQ aborts the transaction.
    @(negedge clk);
    cmd_vld   = 1'b1;
    cmd_rw    = 1'b1;
    cmd_addr  = 20'hABCDE;
    cmd_wdata = 32'hCAFE_0001;
    @(negedge clk);
    cmd_vld = 1'b0;
    check("pre_rst_req", cbus_req, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cbus_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rsp_vld !== 1'b0 || cbus_req !== 1'b0) ok = 1'b0;
    end
    cbus_ack = 1'b0;
    check("post_rst_quiet", ok, 1'b1);
    run_txn(1'b0, 20'h00050, 32'h0, 2, 32'h600D_0002, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
